// File: rtl/alu_pkg.sv
// Shared definitions for the ALU frame controller: opcodes, FSM states and the opcode check.
package alu_pkg;

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'h20;
    localparam logic [OP_W-1:0] OP_SUB = 6'h22;
    localparam logic [OP_W-1:0] OP_AND = 6'h24;
    localparam logic [OP_W-1:0] OP_OR  = 6'h25;
    localparam logic [OP_W-1:0] OP_XOR = 6'h26;
    localparam logic [OP_W-1:0] OP_NOR = 6'h27;
    localparam logic [OP_W-1:0] OP_SRA = 6'h03;
    localparam logic [OP_W-1:0] OP_SRL = 6'h02;

    typedef enum logic [2:0] {
        StIdle,
        StGetB,
        StGetOp,
        StExec,
        StSend,
        StWaitTx
    } state_e;

    // Checks only the opcode field; the caller checks that the upper byte bits are zero.
    function automatic logic is_valid_op(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_frame_timer.sv
// Saturating inter-byte counter; expire_o flags the cycle whose edge would reach TIMEOUT_CYC.
module alu_frame_timer #(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero TIMEOUT_CYC disables expiry entirely.
    assign expire_o = (TIMEOUT_CYC != 0) && en_i && (cnt_q >= (CntMax - CntW'(1)));

endmodule

// File: rtl/alu_frame_ctrl.sv
// Assembles {A, B, opcode} frames from UART RX, drives the ALU and hands the result to UART TX.
module alu_frame_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned NB_DATA     = 8,
    parameter int unsigned NB_OP       = 6,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_err
);

    state_e               state_q, state_d;
    logic [NB_DATA-1:0]   alu_a_q, alu_a_d;
    logic [NB_DATA-1:0]   alu_b_q, alu_b_d;
    logic [NB_OP-1:0]     alu_op_q, alu_op_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic                 err_q, err_d;
    logic                 op_valid;
    logic                 timer_clr, timer_en, timer_expire;

    assign op_valid  = (i_rx_data[NB_DATA-1:NB_OP] == '0) && is_valid_op(i_rx_data[NB_OP-1:0]);
    assign timer_en  = (state_q == StGetB) || (state_q == StGetOp);
    assign timer_clr = (state_q == StIdle) || i_rx_done;

    alu_frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk_i    (i_clk),
        .rst_ni   (i_rst_n),
        .clr_i    (timer_clr),
        .en_i     (timer_en),
        .expire_o (timer_expire)
    );

    // A byte arriving in the expiry cycle takes priority over the timeout.
    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        tx_data_d = tx_data_q;
        err_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_rx_done) begin
                    alu_a_d = i_rx_data;
                    state_d = StGetB;
                end
            end
            StGetB: begin
                if (i_rx_done) begin
                    alu_b_d = i_rx_data;
                    state_d = StGetOp;
                end else if (timer_expire) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StGetOp: begin
                if (i_rx_done) begin
                    if (op_valid) begin
                        alu_op_d = i_rx_data[NB_OP-1:0];
                        state_d  = StExec;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end else if (timer_expire) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StExec: begin
                tx_data_d = i_alu_result;
                state_d   = StSend;
            end
            StSend: begin
                state_d = StWaitTx;
            end
            StWaitTx: begin
                if (i_tx_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            tx_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            tx_data_q <= tx_data_d;
            err_q     <= err_d;
        end
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = (state_q == StSend);
    assign o_busy     = (state_q != StIdle);
    assign o_err      = err_q;

endmodule
